// File: rtl/matrix_pkg.sv
// Shared types and width-dependent constants for the matrix subtractor stream.
package matrix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Largest positive two's-complement value of a w-bit element, zero-extended to 64 bits.
  function automatic logic [63:0] sat_max(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value of a w-bit element, as a 64-bit pattern.
  function automatic logic [63:0] sat_min(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/element_sub_sat.sv
// Combinational signed a-b with overflow detect; clamps when MATRIX_SUB_SATURATE_EN is defined,
// otherwise returns the wrap-around difference.
module element_sub_sat
  import matrix_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              ovf
);

  logic [DATA_W:0] wide;

  // One guard bit: overflow whenever the top two bits of the widened result disagree.
  assign wide = {a[DATA_W-1], a} - {b[DATA_W-1], b};
  assign ovf  = wide[DATA_W] ^ wide[DATA_W-1];

`ifdef MATRIX_SUB_SATURATE_EN
  localparam logic [63:0] MAX64 = sat_max(DATA_W);
  localparam logic [63:0] MIN64 = sat_min(DATA_W);
  localparam logic [DATA_W-1:0] MAX_V = MAX64[DATA_W-1:0];
  localparam logic [DATA_W-1:0] MIN_V = MIN64[DATA_W-1:0];

  // The guard bit carries the true sign of the result, which picks the clamp direction.
  assign result = ovf ? (wide[DATA_W] ? MIN_V : MAX_V) : wide[DATA_W-1:0];
`else
  assign result = wide[DATA_W-1:0];
`endif

endmodule

// File: rtl/matrix_subtractor_stream.sv
// Streams ROWS*COLS element pairs through a one-stage registered subtractor with valid/ready
// on both sides. Optional clamping of overflowed results: MATRIX_SUB_SATURATE_EN.
module matrix_subtractor_stream
  import matrix_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ROWS   = 3,
  parameter int COLS   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] diff_out,
  output logic              ovf_out,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              ovf_any
);

  localparam int N     = ROWS * COLS;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              out_valid_reg;
  logic [DATA_W-1:0] diff_reg;
  logic              ovf_reg;
  logic              last_reg;
  logic              done_reg;
  logic              ovf_any_reg;

  logic [DATA_W-1:0] sub_result;
  logic              sub_ovf;
  logic              accept;
  logic              out_fire;
  logic              last_accept;

  element_sub_sat #(.DATA_W(DATA_W)) u_sub (
    .a      (a_in),
    .b      (b_in),
    .result (sub_result),
    .ovf    (sub_ovf)
  );

  // The output slot may be refilled in the same cycle it drains.
  assign in_ready    = (state_reg == ST_RUN) && (!out_valid_reg || out_ready);
  assign accept      = in_valid && in_ready;
  assign out_fire    = out_valid_reg && out_ready;
  assign last_accept = accept && (cnt_reg == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      diff_reg      <= '0;
      ovf_reg       <= 1'b0;
      last_reg      <= 1'b0;
      done_reg      <= 1'b0;
      ovf_any_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // A start coinciding with the completion pulse belongs to the finished operation.
          if (start && !done_reg) begin
            state_reg   <= ST_RUN;
            cnt_reg     <= '0;
            ovf_any_reg <= 1'b0;
          end
        end
        ST_RUN: begin
          if (last_accept) begin
            state_reg <= ST_FLUSH;
          end else if (accept) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_FLUSH: begin
          if (out_fire && last_reg) begin
            state_reg <= ST_IDLE;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase

      if (accept) begin
        out_valid_reg <= 1'b1;
        diff_reg      <= sub_result;
        ovf_reg       <= sub_ovf;
        last_reg      <= last_accept;
        ovf_any_reg   <= ovf_any_reg | sub_ovf;
      end else if (out_fire) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign diff_out  = diff_reg;
  assign ovf_out   = ovf_reg;
  assign out_last  = last_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign done      = done_reg;
  assign ovf_any   = ovf_any_reg;

endmodule

// File: tb/tb_matrix_subtractor_stream.sv
// Scoreboard bench: driver pushes expected results on each accepted pair, a negedge monitor pops them.
module tb_matrix_subtractor_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, in_valid, out_ready;
  logic [15:0] a_in, b_in;
  logic        in_ready, out_valid, ovf_out, out_last, busy, done, ovf_any;
  logic [15:0] diff_out;

  logic        s_start, s_in_valid;
  logic [15:0] s_a, s_b;
  logic        s_in_ready, s_out_valid, s_ovf_out, s_out_last, s_busy, s_done, s_ovf_any;
  logic [15:0] s_diff;

`ifdef MATRIX_SUB_SATURATE_EN
  localparam logic [15:0] POS_OVF = 16'h7FFF;
  localparam logic [15:0] NEG_OVF = 16'h8000;
`else
  localparam logic [15:0] POS_OVF = 16'h8000;
  localparam logic [15:0] NEG_OVF = 16'h7FFF;
`endif

  matrix_subtractor_stream #(.DATA_W(16), .ROWS(3), .COLS(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .diff_out(diff_out), .ovf_out(ovf_out), .out_last(out_last), .busy(busy),
    .done(done), .ovf_any(ovf_any)
  );

  matrix_subtractor_stream #(.DATA_W(16), .ROWS(1), .COLS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a_in(s_a), .b_in(s_b), .out_valid(s_out_valid), .out_ready(1'b1),
    .diff_out(s_diff), .ovf_out(s_ovf_out), .out_last(s_out_last), .busy(s_busy),
    .done(s_done), .ovf_any(s_ovf_any)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        o;
    logic        l;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cycle = 0;
  int          done_cnt = 0;
  int          last_hs_cycle = -10;
  bit          stall_en = 0;
  int          pidx = 0;
  bit          hold_valid = 0;
  logic [15:0] hold_d;
  logic        hold_o, hold_l;

  logic [15:0] va[9], vb[9], vd[9];
  logic        vo[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic finish_now();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  always @(posedge clk) cycle++;

  // Output-side backpressure: 1,0,0,1 repeating while stalling is enabled.
  always @(posedge clk) begin
    #1;
    if (stall_en) begin
      out_ready = (pidx == 1 || pidx == 2) ? 1'b0 : 1'b1;
      pidx = (pidx + 1) % 4;
    end else begin
      out_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_valid = 0;
    end else begin
      if (hold_valid)
        chk("stall_hold", {13'd0, out_valid, ovf_out, out_last, diff_out},
            {13'd0, 1'b1, hold_o, hold_l, hold_d});
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        hold_valid = 1;
        hold_d = diff_out;
        hold_o = ovf_out;
        hold_l = out_last;
      end else begin
        hold_valid = 0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("diff_out", {16'd0, diff_out}, {16'd0, e.d});
          chk("ovf_out", {31'd0, ovf_out}, {31'd0, e.o});
          chk("out_last", {31'd0, out_last}, {31'd0, e.l});
          if (out_last) last_hs_cycle = cycle;
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_latency", cycle, last_hs_cycle + 1);
        chk("done_idle", {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic load_set(input int s);
    case (s)
      0: for (int k = 0; k < 9; k++) begin
           va[k] = 16'(k + 10); vb[k] = 16'(k); vd[k] = 16'd10; vo[k] = 1'b0;
         end
      1: begin
           va = '{16'h7FFF, 16'h8000, 16'h0005, 16'h8000, 16'hFFFF, 16'h0000, 16'h1234, 16'h0001, 16'h7FFF};
           vb = '{16'hFFFF, 16'h0001, 16'h0007, 16'h8000, 16'h7FFF, 16'h8000, 16'h0234, 16'h0002, 16'h0000};
           vd = '{POS_OVF,  NEG_OVF,  16'hFFFE, 16'h0000, 16'h8000, POS_OVF,  16'h1000, 16'hFFFF, 16'h7FFF};
           vo = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
         end
      default: begin
           va = '{16'h0064, 16'h0000, 16'hFF9C, 16'h3000, 16'hABCD, 16'h0100, 16'h8001, 16'h7FFE, 16'h0010};
           vb = '{16'h0032, 16'h0001, 16'h0064, 16'hD000, 16'hABCD, 16'h0001, 16'h0001, 16'hFFFF, 16'h0020};
           vd = '{16'h0032, 16'hFFFF, 16'hFF38, 16'h6000, 16'h0000, 16'h00FF, 16'h8000, 16'h7FFF, 16'hFFF0};
           vo = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
         end
    endcase
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_outs"}, {24'd0, out_valid, ovf_out, out_last, done, ovf_any, busy, in_ready, 1'b0},
        32'd0);
    chk({tag, "_diff"}, {16'd0, diff_out}, 32'd0);
  endtask

  // One operation of nine pairs; noise keeps start high throughout; abort_after>0 resets mid-stream.
  task automatic run_op(input bit noise, input int abort_after);
    int   to;
    int   base_done;
    logic exp_any;
    exp_t e;
    base_done = done_cnt;
    exp_any = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = noise;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 9; k++) begin
      in_valid = 1'b1; a_in = va[k]; b_in = vb[k];
      to = 0;
      while (1) begin
        @(negedge clk);
        if (in_ready) break;
        to++;
        if (to > 100) begin
          chk("accept_timeout", 32'd1, 32'd0);
          finish_now();
        end
        @(posedge clk); #1;
      end
      e.d = vd[k]; e.o = vo[k]; e.l = (k == 8);
      sb.push_back(e);
      exp_any = exp_any | vo[k];
      @(posedge clk); #1;
      if (abort_after == k + 1) begin
        rst_n = 1'b0; in_valid = 1'b0; start = 1'b0;
        hold_valid = 0;
        sb.delete();
        #1;
        check_reset_outputs("abort_reset");
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("abort_no_done", done_cnt, base_done);
        return;
      end
    end
    in_valid = 1'b0;
    to = 0;
    while (done_cnt == base_done && to < 200) begin
      @(posedge clk);
      to++;
    end
    #1 start = 1'b0;
    chk("done_count", done_cnt - base_done, 32'd1);
    chk("ovf_any_at_done", {31'd0, ovf_any}, {31'd0, exp_any});
    chk("sb_empty", sb.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("idle_after_done", {31'd0, busy}, 32'd0);
    chk("single_done", done_cnt - base_done, 32'd1);
    chk("ovf_any_holds", {31'd0, ovf_any}, {31'd0, exp_any});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0; out_ready = 1'b1;
    s_start = 1'b0; s_in_valid = 1'b0; s_a = '0; s_b = '0;
    #23;
    check_reset_outputs("por");
    @(negedge clk) rst_n = 1'b1;

    load_set(0); run_op(1'b0, 0);
    load_set(1); run_op(1'b0, 0);
    stall_en = 1; load_set(2); run_op(1'b1, 0); stall_en = 0;
    load_set(2); run_op(1'b0, 4);
    load_set(1); run_op(1'b0, 0);

    // Single-element matrix: 7 - 3 = 4.
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    chk("n1_ready", {30'd0, s_busy, s_in_ready}, 32'd3);
    s_in_valid = 1'b1; s_a = 16'd7; s_b = 16'd3;
    @(posedge clk); #1 s_in_valid = 1'b0;
    chk("n1_out", {13'd0, s_out_valid, s_out_last, s_ovf_out, s_diff}, {13'd0, 3'b110, 16'd4});
    chk("n1_flush", {29'd0, s_busy, s_in_ready, s_done}, 32'd4);
    @(posedge clk); #1;
    chk("n1_done", {29'd0, s_done, s_busy, s_out_valid}, 32'd4);
    @(posedge clk); #1;
    chk("n1_done_pulse", {31'd0, s_done}, 32'd0);

    finish_now();
  end

endmodule

// File: doc/matrix_subtractor_stream.md
MATRIX_SUBTRACTOR_STREAM -- requirements
Module: matrix_subtractor_stream

Interface
REQ-001 Parameter DATA_W, default 16: element width in bits, two's-complement.
REQ-002 Parameter ROWS, default 3: matrix rows, 1..64.
REQ-003 Parameter COLS, default 3: matrix columns, 1..64.
REQ-004 clk  in  1: single clock; all state on rising edge.
REQ-005 rst_n  in  1: asynchronous assert, active-low reset.
REQ-006 start  in  1: begin one matrix operation; sampled only in IDLE.
REQ-007 in_valid  in  1: a_in/b_in pair valid.
REQ-008 in_ready  out  1: block accepts pair this cycle.
REQ-009 a_in  in  DATA_W: minuend element, row-major order.
REQ-010 b_in  in  DATA_W: subtrahend element.
REQ-011 out_valid  out  1: diff_out valid.
REQ-012 out_ready  in  1: downstream accepts diff_out.
REQ-013 diff_out  out  DATA_W: a_in - b_in for the element.
REQ-014 ovf_out  out  1: per-element signed overflow flag, aligned with diff_out.
REQ-015 out_last  out  1: marks element ROWS*COLS-1.
REQ-016 busy  out  1: high in RUN and FLUSH.
REQ-017 done  out  1: one-cycle pulse on operation completion.
REQ-018 ovf_any  out  1: sticky OR of ovf_out across current operation.

Function
REQ-019 FSM states IDLE, RUN, FLUSH; IDLE->RUN when start=1; RUN->FLUSH on acceptance of element N-1 (N=ROWS*COLS); FLUSH->IDLE when final element handshakes out.
REQ-020 Transfer occurs on a port only when valid and ready are both 1 in the same cycle.
REQ-021 in_ready = (state==RUN) && (!out_valid || out_ready); zero in IDLE and FLUSH.
REQ-022 Single output register stage: accepted pair appears on diff_out exactly one cycle later; full throughput of one element per cycle when out_ready held 1.
REQ-023 While out_valid=1 and out_ready=0, diff_out, ovf_out, out_last held stable.
REQ-024 Subtraction in DATA_W+1 bits; ovf_out=1 when signed result outside DATA_W range.
REQ-025 Element counter width $clog2(N) (min 1); increments per accepted pair; clears on entry to RUN; no wrap within an operation.
REQ-026 out_last=1 exactly on output of counter value N-1.
REQ-027 done asserted in the cycle after final output handshake, coincident with return to IDLE.
REQ-028 start while busy ignored; start in same cycle as done pulse ignored (still IDLE-entry cycle rules: accepted only when state==IDLE at sampling edge).
REQ-029 ovf_any cleared on IDLE->RUN; holds value after done until next start.
REQ-030 N=1: single element; RUN->FLUSH on first acceptance.

Reset
REQ-031 rst_n low asynchronously forces: state IDLE, counter 0, out_valid 0, diff_out 0, ovf_out 0, out_last 0, done 0, ovf_any 0, busy 0.
REQ-032 Reset mid-operation discards in-flight element; no done pulse; next start begins fresh operation.

Configuration
REQ-033 Macro MATRIX_SUB_SATURATE_EN defined: on overflow diff_out clamps to signed max (positive overflow) or signed min (negative); ovf_out still asserted.
REQ-034 Macro undefined: diff_out is DATA_W-bit wrap-around result; ovf_out unchanged in meaning.

Structure
REQ-035 Shared package matrix_pkg holds FSM state enum type and saturation min/max constant functions of DATA_W.
REQ-036 One sub-module element_sub_sat: combinational DATA_W subtract producing result and overflow, honoring MATRIX_SUB_SATURATE_EN; top holds FSM, counter, output register.

Verification
REQ-037 DATA_W=16, 3x3, out_ready=1, 9 pairs a=k+10, b=k -> nine outputs of 10, out_last on 9th, done one cycle after, ovf_any=0.
REQ-038 a=0x7FFF, b=0xFFFF (-1) -> ovf_out=1; diff_out 0x7FFF with macro, 0x8000 without; ovf_any=1 at done.
REQ-039 out_ready toggled 1,0,0,1 pattern during streaming -> no element lost/duplicated, diff_out stable while stalled, in_ready=0 while output full and stalled.
REQ-040 start pulsed during RUN and FLUSH -> ignored; exactly one done per operation.
REQ-041 rst_n asserted after 4 of 9 elements -> outputs at reset values immediately; subsequent full operation yields 9 correct outputs and one done.
REQ-042 ROWS=1, COLS=1 -> single output with out_last=1, done next cycle after handshake.
